// File: rtl/rv_iopmp_err_queue.sv
// rv_iopmp_err_queue: in-order FIFO of IOPMP violation records with a saturating overflow count and a WSI line.
// Optional timestamp capture is enabled by defining RV_IOPMP_ERR_TS_EN.
module rv_iopmp_err_queue #(
    parameter int ADDR_WIDTH = 64,
    parameter int SID_WIDTH  = 1,
    parameter int DEPTH      = 4,
    parameter int OVF_WIDTH  = 8,
    parameter int TS_WIDTH   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       err_valid_i,
    input  logic [ADDR_WIDTH-1:0]      err_addr_i,
    input  logic [SID_WIDTH-1:0]       err_sid_i,
    input  logic [1:0]                 err_access_i,
    input  logic [2:0]                 err_type_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic                       irq_en_i,
    output logic                       head_valid_o,
    output logic [ADDR_WIDTH-1:0]      head_addr_o,
    output logic [SID_WIDTH-1:0]       head_sid_o,
    output logic [1:0]                 head_access_o,
    output logic [2:0]                 head_type_o,
`ifdef RV_IOPMP_ERR_TS_EN
    output logic [TS_WIDTH-1:0]        head_ts_o,
`endif
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [OVF_WIDTH-1:0]       ovf_cnt_o,
    output logic                       wsi_wire_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_bad_cfg
        $error("rv_iopmp_err_queue: DEPTH must be a power of two >= 2 and TS_WIDTH >= 1");
    end

    logic [ADDR_WIDTH-1:0] r_addr   [DEPTH];
    logic [SID_WIDTH-1:0]  r_sid    [DEPTH];
    logic [1:0]            r_access [DEPTH];
    logic [2:0]            r_type   [DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic [OVF_WIDTH-1:0]  r_ovf;
    logic                  r_wsi;

    logic                  w_full, w_push, w_pop, w_accept, w_drop;
    logic [CW-1:0]         w_count_n;
    logic [OVF_WIDTH-1:0]  w_ovf_n;

    // clear outranks push and pop, so a concurrent push is neither stored nor counted
    always_comb begin
        w_full    = r_count == CW'(DEPTH);
        w_push    = err_valid_i & enable_i & (err_type_i != 3'd0) & ~clear_i;
        w_pop     = pop_i & (r_count != '0) & ~clear_i;
        w_accept  = w_push & (~w_full | w_pop);
        w_drop    = w_push & w_full & ~w_pop;
        w_count_n = clear_i ? '0 : r_count + CW'(w_accept) - CW'(w_pop);
        w_ovf_n   = clear_i ? '0 : (w_drop && r_ovf != '1) ? r_ovf + OVF_WIDTH'(1) : r_ovf;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]   <= '0;
                r_sid[i]    <= '0;
                r_access[i] <= '0;
                r_type[i]   <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= '0;
            r_wsi   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr[r_wptr]   <= err_addr_i;
                r_sid[r_wptr]    <= err_sid_i;
                r_access[r_wptr] <= err_access_i;
                r_type[r_wptr]   <= err_type_i;
                r_wptr           <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            if (clear_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end
            r_count <= w_count_n;
            r_ovf   <= w_ovf_n;
            r_wsi   <= irq_en_i & ((w_count_n != '0) | (w_ovf_n != '0));
        end
    end

`ifdef RV_IOPMP_ERR_TS_EN
    logic [TS_WIDTH-1:0] r_ts;
    logic [TS_WIDTH-1:0] r_ts_mem [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ts <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_ts_mem[i] <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            if (w_accept)
                r_ts_mem[r_wptr] <= r_ts;
        end
    end

    assign head_ts_o = head_valid_o ? r_ts_mem[r_rptr] : '0;
`endif

    assign head_valid_o  = r_count != '0;
    assign head_addr_o   = head_valid_o ? r_addr[r_rptr]   : '0;
    assign head_sid_o    = head_valid_o ? r_sid[r_rptr]    : '0;
    assign head_access_o = head_valid_o ? r_access[r_rptr] : '0;
    assign head_type_o   = head_valid_o ? r_type[r_rptr]   : '0;
    assign count_o       = r_count;
    assign ovf_cnt_o     = r_ovf;
    assign wsi_wire_o    = r_wsi;
endmodule

// File: doc/rv_iopmp_err_queue.md
Name: rv_iopmp_err_queue

Overview:
- Downstream consumer of violation reports from the IOPMP matching logic.
- Buffers error records in a small in-order FIFO so that software can read, through the register map, violations that arrive back-to-back.
- Counts records lost to overflow.
- Drives the wired-signalled interrupt (WSI) line while records are pending.

Parameters:
ADDR_WIDTH, 64, width of the captured transaction address
SID_WIDTH, 1, width of the captured source ID
DEPTH, 4, number of record slots; power of two, at least 2
OVF_WIDTH, 8, width of the saturating overflow counter
TS_WIDTH, 32, timestamp width; used only when RV_IOPMP_ERR_TS_EN is defined

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
enable_i  in  1  capture enable (IOPMP enabled and error reporting on)
err_valid_i  in  1  single-cycle violation report from the matching logic
err_addr_i  in  ADDR_WIDTH  faulting address
err_sid_i  in  SID_WIDTH  faulting source ID
err_access_i  in  2  access type: 1 = read, 2 = write, 3 = read+write
err_type_i  in  3  error type code (0 is reserved and never pushed)
pop_i  in  1  single-cycle strobe from the regmap; discards the head record
clear_i  in  1  flush all records and zero the overflow count
irq_en_i  in  1  interrupt enable
head_valid_o  out  1  queue not empty
head_addr_o  out  ADDR_WIDTH  head record address
head_sid_o  out  SID_WIDTH  head record SID
head_access_o  out  2  head record access type
head_type_o  out  3  head record error type
count_o  out  $clog2(DEPTH)+1  records held
ovf_cnt_o  out  OVF_WIDTH  dropped-record counter, saturating
wsi_wire_o  out  1  interrupt line (level signalled)

Behaviour:
- Storage and pointers:
  - Circular buffer with write pointer, read pointer and occupancy counter.
  - Pointers wrap modulo DEPTH.
  - Head outputs come directly from the storage slot at the read pointer: zero added latency.
  - Head outputs read as all-zero when the queue is empty.
- Reset: all outputs are 0, pointers are 0, ovf_cnt_o is 0, storage is zeroed.
  - Reset takes effect in the middle of any operation and discards all records.
- Push condition: err_valid_i & enable_i & (err_type_i != 0).
  - The record is written at the rising edge.
  - It is visible on the head outputs and count_o the next cycle if the queue was empty.
- Pop: pop_i with count_o > 0 advances the read pointer.
  - pop_i while empty is ignored: no pointer or count change.
- Simultaneous push and pop:
  - Not full: both happen and count is unchanged.
  - Full: the pop frees a slot, so the push is accepted; no drop and no overflow increment.
- Push while full without pop: the record is dropped.
  - ovf_cnt_o increments and saturates at 2^OVF_WIDTH-1.
  - Stored records are unchanged; the oldest record is retained.
- clear_i has priority over push and pop in the same cycle:
  - pointers and count go to 0;
  - ovf_cnt_o goes to 0;
  - the concurrent push is discarded and not counted.
- Interrupt: wsi_wire_o is registered as irq_en_i & ((count != 0) | (ovf_cnt != 0)), evaluated on next-state values.
  - It rises one cycle after the push that fills an empty queue.
  - It falls one cycle after the final pop, if ovf_cnt_o is 0.
- Deasserting enable_i blocks new pushes only; queued records remain and can still be popped.
- count_o never exceeds DEPTH.

Optional Feature:
- Macro RV_IOPMP_ERR_TS_EN.
- When defined:
  - Adds a free-running TS_WIDTH counter that is reset to 0 and wraps at its maximum.
  - Adds output port head_ts_o [TS_WIDTH], carrying the counter value sampled in the push cycle.
  - Dropped records do not consume timestamps in any special way.
- When undefined: the counter and the port are absent, and all other behaviour is identical.

Test Plan:
- Reset with err_valid_i=1 held -> head_valid_o=0, count_o=0, ovf_cnt_o=0, wsi_wire_o=0 throughout reset.
- DEPTH=4, irq_en_i=1; push addr 0x1000, sid 1, access 2, type 1 -> next cycle: head_addr_o=0x1000, count_o=1, wsi_wire_o=1; pop -> count_o=0, wsi_wire_o=0 one cycle later.
- Push 6 records back-to-back (addr 0x0,0x10,…,0x50) -> count_o=4, ovf_cnt_o=2; four pops return 0x0,0x10,0x20,0x30 in order.
- Fill to 4, then push and pop in the same cycle -> count_o stays 4, ovf_cnt_o stays 0, new head is the second record, new record lands at the tail.
- With OVF_WIDTH=2, fill the queue and push 5 more -> ovf_cnt_o=3 (saturated); clear_i with concurrent push -> count_o=0, ovf_cnt_o=0, wsi_wire_o=0.
- With RV_IOPMP_ERR_TS_EN: push at cycles 10 and 13 after reset release -> head_ts_o=10, then 13 after a pop; pop on empty and push with err_type_i=0 -> no state change.
